deserializer: RTL and testbench

Receive side of the team's MSB-first serial link: accepts a bit stream qualified by a valid strobe and reassembles it into parallel words of up to `DATA_BUS_WIDTH` bits. Each word comes out with a bit-count (`mod`) field. A contiguous run of valid bits forms one frame. A frame ends either when the word is full or when the valid strobe drops; a partial word is emitted at that point. The block sits after the serial line and feeds a parallel consumer that has no back-pressure.

---
 rtl/deserializer.sv | 113 +++++++++++
 tb/tb_deserializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver emitting words with a bit-count (mod) field.
// Optional DESER_DROP_SHORT_EN: silently discard partial frames of 1 or 2 bits.
module deserializer #(
   parameter int unsigned DATA_BUS_WIDTH = 16,
   parameter int unsigned DATA_MOD_WIDTH = 4
) (
   input  logic                      clk_i,
   input  logic                      srst_i,
   input  logic                      ser_data_i,
   input  logic                      ser_data_val_i,
   output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
   output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
   output logic                      deser_data_val_o,
   output logic                      busy_o
);

   localparam int unsigned CntW = DATA_MOD_WIDTH + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DATA_BUS_WIDTH);

   typedef enum logic [1:0] {
      IdleS = 2'd0,
      RecvS = 2'd1
   } state_e;

   state_e                    state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [DATA_BUS_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
   logic [DATA_MOD_WIDTH-1:0] mod_q, mod_d;
   logic                      val_q, val_d;

   logic [CntW-1:0]           cnt_inc;
   logic [DATA_BUS_WIDTH-1:0] ins_bit;
   logic [DATA_BUS_WIDTH-1:0] shreg_next;
   logic                      drop_short;

   // Incoming bit lands at position W-1-cnt; unwritten positions stay 0.
   assign ins_bit    = (DATA_BUS_WIDTH'(ser_data_i) << (DATA_BUS_WIDTH - 1)) >> cnt_q;
   assign shreg_next = shreg_q | ins_bit;
   assign cnt_inc    = cnt_q + CntW'(1);

`ifdef DESER_DROP_SHORT_EN
   assign drop_short = (cnt_q <= CntW'(2));
`else
   assign drop_short = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      mod_d   = mod_q;
      val_d   = 1'b0;
      case (state_q)
         IdleS, RecvS: begin
            if (ser_data_val_i) begin
               // Also covers DATA_BUS_WIDTH=1, where the first bit already fills a word.
               if (cnt_inc == FullCnt) begin
                  val_d   = 1'b1;
                  data_d  = shreg_next;
                  mod_d   = '0;
                  shreg_d = '0;
                  cnt_d   = '0;
                  state_d = IdleS;
               end else begin
                  shreg_d = shreg_next;
                  cnt_d   = cnt_inc;
                  state_d = RecvS;
               end
            end else if (state_q == RecvS) begin
               if (!drop_short) begin
                  val_d  = 1'b1;
                  data_d = shreg_q;
                  mod_d  = cnt_q[DATA_MOD_WIDTH-1:0];
               end
               shreg_d = '0;
               cnt_d   = '0;
               state_d = IdleS;
            end
         end
         default: begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IdleS;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         state_q <= IdleS;
         cnt_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         mod_q   <= '0;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         mod_q   <= mod_d;
         val_q   <= val_d;
      end
   end

   assign deser_data_o     = data_q;
   assign deser_data_mod_o = mod_q;
   assign deser_data_val_o = val_q;
   assign busy_o           = (state_q == RecvS);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus random streams
// compared against a word-packing reference model.
module tb_deserializer;

   localparam int W = 16;
   localparam int M = 4;

   logic         clk = 1'b0;
   logic         srst = 1'b1;
   logic         sd = 1'b0;
   logic         sv = 1'b0;
   logic [W-1:0] ddata;
   logic [M-1:0] dmod;
   logic         dval;
   logic         busy;

   deserializer #(
      .DATA_BUS_WIDTH(W),
      .DATA_MOD_WIDTH(M)
   ) dut (
      .clk_i           (clk),
      .srst_i          (srst),
      .ser_data_i      (sd),
      .ser_data_val_i  (sv),
      .deser_data_o    (ddata),
      .deser_data_mod_o(dmod),
      .deser_data_val_o(dval),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] data;
      logic [M-1:0] mod;
      int           cyc;
   } ev_t;

   ev_t act_q[$];
   ev_t exp_q[$];
   bit  stim_v[$];
   bit  stim_b[$];
   int  checks = 0;
   int  errors = 0;
   bit  drop_short;

   always @(negedge clk) if (dval) act_q.push_back('{ddata, dmod, cyc});

   task automatic push_word(input logic [W-1:0] value, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         stim_v.push_back(1'b1);
         stim_b.push_back(value[i]);
      end
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) begin
         stim_v.push_back(1'b0);
         stim_b.push_back(1'b0);
      end
   endtask

   // Drives the queued stream one entry per cycle and builds the expected word list:
   // each valid run is cut into W-bit words, any remainder is left-justified with mod=len.
   task automatic run_stream(input string name);
      int           base;
      int           n;
      int           nmin;
      logic [W-1:0] acc;
      bit           busy_exp;
      push_idle(1);
      exp_q.delete();
      act_q.delete();
      n = 0;
      acc = '0;
      busy_exp = 1'b0;
      @(negedge clk);
      base = cyc;
      for (int i = 0; i < stim_v.size(); i++) begin
         if (i > 0) begin
            checks++;
            if (busy !== busy_exp) begin
               errors++;
               $display("FAIL %s busy@%0d: got %b want %b", name, i, busy, busy_exp);
            end
         end
         sv = stim_v[i];
         sd = stim_b[i];
         if (stim_v[i]) begin
            acc = acc * 2 + W'(stim_b[i]);
            n++;
            if (n == W) begin
               exp_q.push_back('{acc, M'(0), base + i + 1});
               n = 0;
               acc = '0;
            end
         end else if (n > 0) begin
            if (!(drop_short && n <= 2)) exp_q.push_back('{acc << (W - n), M'(n), base + i + 1});
            n = 0;
            acc = '0;
         end
         busy_exp = (n != 0);
         @(negedge clk);
      end
      sv = 1'b0;
      sd = 1'b0;
      checks++;
      if (busy !== busy_exp) begin
         errors++;
         $display("FAIL %s busy@end: got %b want %b", name, busy, busy_exp);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (act_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s pulse count: got %0d want %0d", name, act_q.size(), exp_q.size());
      end
      nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int k = 0; k < nmin; k++) begin
         checks++;
         if (act_q[k].data !== exp_q[k].data || act_q[k].mod !== exp_q[k].mod ||
             act_q[k].cyc != exp_q[k].cyc) begin
            errors++;
            $display("FAIL %s word%0d: got %h/mod%0d@%0d want %h/mod%0d@%0d", name, k,
                     act_q[k].data, act_q[k].mod, act_q[k].cyc - base,
                     exp_q[k].data, exp_q[k].mod, exp_q[k].cyc - base);
         end
      end
      stim_v.delete();
      stim_b.delete();
   endtask

   task automatic test_reset();
      checks++;
      if (ddata !== '0 || dmod !== '0 || dval !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: got %h/%h/%b/%b want 0/0/0/0", ddata, dmod, dval, busy);
      end
   endtask

   task automatic test_full_word();
      push_word(16'hA5C3, 16);
      run_stream("full_word");
   endtask

   task automatic test_partial();
      push_word(16'h0016, 5);
      run_stream("partial");
      checks++;
      if (ddata !== 16'hB000 || dmod !== 4'd5) begin
         errors++;
         $display("FAIL partial hold: got %h/%0d want b000/5", ddata, dmod);
      end
   endtask

   task automatic test_back_to_back();
      push_word(16'hFFFF, 16);
      push_word(16'h0001, 16);
      run_stream("back_to_back");
   endtask

   task automatic test_short();
      push_word(16'h0003, 2);
      run_stream("short");
      push_word(16'h0001, 1);
      push_idle(2);
      push_word(16'h0005, 3);
      run_stream("short_1_3");
   endtask

   task automatic test_gap();
      push_word(16'h0007, 3);
      push_idle(1);
      push_word(16'h0001, 4);
      run_stream("gap");
   endtask

   task automatic test_reset_mid_frame();
      act_q.delete();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         sv = 1'b1;
         sd = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      sv = 1'b0;
      sd = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid busy before: got %b want 1", busy);
      end
      @(posedge clk);
      #2 srst = 1'b1;
      #1;
      checks++;
      if (ddata !== '0 || dmod !== '0 || dval !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid outputs: got %h/%h/%b/%b want 0/0/0/0", ddata, dmod, dval, busy);
      end
      repeat (2) @(negedge clk);
      srst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (act_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid stray pulses: got %0d want 0", act_q.size());
      end
      push_word(16'h1234, 16);
      run_stream("after_reset");
   endtask

   task automatic test_random();
      for (int t = 0; t < 12; t++) begin
         int len;
         len = $urandom_range(1, 60);
         for (int i = 0; i < len; i++) begin
            stim_v.push_back($urandom_range(0, 9) < 8);
            stim_b.push_back(1'($urandom_range(0, 1)));
         end
         run_stream($sformatf("random%0d", t));
      end
   endtask

   initial begin
`ifdef DESER_DROP_SHORT_EN
      drop_short = 1'b1;
`else
      drop_short = 1'b0;
`endif
      repeat (3) @(negedge clk);
      test_reset();
      srst = 1'b0;
      @(negedge clk);
      test_reset();
      test_full_word();
      test_partial();
      test_back_to_back();
      test_short();
      test_gap();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
